img2col_reader: RTL and testbench

//   Upstream read master for the single-port tensor RAM (ram_t1 port A). Walks a KxK window over an
//   IMG_H x IMG_W single-channel feature map at base_addr, issues read-only RAM accesses, and emits

---
 rtl/img2col_reader.sv | 184 ++++++++++++++++++
 tb/tb_img2col_reader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/img2col_reader.sv
// img2col read master: walks a KxK window over a padded IMG_H x IMG_W map, reads pixels from a
// synchronous single-port RAM and streams them in (oy, ox, ky, kx) order through a 2-entry FIFO.
module img2col_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_SIZE  = 16,
    parameter int IMG_H      = 4,
    parameter int IMG_W      = 4,
    parameter int K          = 3,
    parameter int PAD        = 1,
    parameter int STRIDE     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_SIZE-1:0]  base_addr,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_SIZE-1:0]  ram_addr,
    output logic                  ram_en,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_eop,
    output logic                  m_last
);

    localparam int OH   = (IMG_H + 2*PAD - K)/STRIDE + 1;
    localparam int OW   = (IMG_W + 2*PAD - K)/STRIDE + 1;
    localparam int M1   = (OH > OW) ? OH : OW;
    localparam int MAXV = (M1 > K) ? M1 : K;
    localparam int CW   = $clog2(MAXV + 1);

    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t OH_M1 = cnt_t'(OH - 1);
    localparam cnt_t OW_M1 = cnt_t'(OW - 1);
    localparam cnt_t K_M1  = cnt_t'(K - 1);
    localparam cnt_t ONE   = cnt_t'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state_q, state_d;
    cnt_t   oy_q, ox_q, ky_q, kx_q;
    cnt_t   oy_d, ox_d, ky_d, kx_d;
    logic [ADDR_SIZE-1:0] base_q, base_d;
    logic   infl_q, infl_d;
    logic   infl_eop_q, infl_eop_d;
    logic   infl_last_q, infl_last_d;

    logic [DATA_WIDTH-1:0] fd_q [2];
    logic [1:0] feop_q, flast_q;
    logic       wp_q, rp_q;
    logic [1:0] cnt_q;

    int   iy, ix;
    logic in_bounds, elem_eop, elem_last;
    logic pop, push, issue, issue_rd, issue_pad;
    logic [2:0] occ;
    logic [ADDR_SIZE-1:0] addr;

    always_comb begin
        iy        = int'(oy_q)*STRIDE + int'(ky_q) - PAD;
        ix        = int'(ox_q)*STRIDE + int'(kx_q) - PAD;
        in_bounds = (iy >= 0) && (iy < IMG_H) && (ix >= 0) && (ix < IMG_W);
        addr      = base_q + ADDR_SIZE'(iy*IMG_W + ix);
        elem_eop  = (ky_q == K_M1) && (kx_q == K_M1);
        elem_last = elem_eop && (oy_q == OH_M1) && (ox_q == OW_M1);
        pop       = (cnt_q != 2'd0) && m_ready;
        // Credit counts the slot freed by a same-cycle pop so a steady stream sustains 1 element/clk.
        occ       = 3'(cnt_q) + 3'(infl_q) - 3'(pop);
        issue     = (state_q == S_RUN) && (occ < 3'd2) && !(!in_bounds && infl_q);
        issue_rd  = issue && in_bounds;
        issue_pad = issue && !in_bounds;
        push      = infl_q || issue_pad;
    end

    always_comb begin
        state_d     = state_q;
        oy_d        = oy_q;
        ox_d        = ox_q;
        ky_d        = ky_q;
        kx_d        = kx_q;
        base_d      = base_q;
        infl_d      = issue_rd;
        infl_eop_d  = elem_eop;
        infl_last_d = elem_last;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    base_d  = base_addr;
                    oy_d    = '0;
                    ox_d    = '0;
                    ky_d    = '0;
                    kx_d    = '0;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (kx_q == K_M1) begin
                        kx_d = '0;
                        if (ky_q == K_M1) begin
                            ky_d = '0;
                            if (ox_q == OW_M1) begin
                                ox_d = '0;
                                oy_d = (oy_q == OH_M1) ? '0 : oy_q + ONE;
                            end else begin
                                ox_d = ox_q + ONE;
                            end
                        end else begin
                            ky_d = ky_q + ONE;
                        end
                    end else begin
                        kx_d = kx_q + ONE;
                    end
                    if (elem_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((cnt_q == 2'd0) && !infl_q) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            oy_q        <= '0;
            ox_q        <= '0;
            ky_q        <= '0;
            kx_q        <= '0;
            base_q      <= '0;
            infl_q      <= 1'b0;
            infl_eop_q  <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            oy_q        <= oy_d;
            ox_q        <= ox_d;
            ky_q        <= ky_d;
            kx_q        <= kx_d;
            base_q      <= base_d;
            infl_q      <= infl_d;
            infl_eop_q  <= infl_eop_d;
            infl_last_q <= infl_last_d;
        end
    end

    // A pad is never issued while a read is in flight, so the FIFO has a single write source per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fd_q[0] <= '0;
            fd_q[1] <= '0;
            feop_q  <= '0;
            flast_q <= '0;
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (push) begin
                fd_q[wp_q]    <= infl_q ? ram_dout : '0;
                feop_q[wp_q]  <= infl_q ? infl_eop_q : elem_eop;
                flast_q[wp_q] <= infl_q ? infl_last_q : elem_last;
                wp_q          <= ~wp_q;
            end
            if (pop) rp_q <= ~rp_q;
            cnt_q <= cnt_q + 2'(push) - 2'(pop);
        end
    end

    assign ram_en   = issue_rd;
    assign ram_addr = issue_rd ? addr : '0;
    assign ram_we   = 1'b0;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign m_valid  = (cnt_q != 2'd0);
    assign m_data   = m_valid ? fd_q[rp_q] : '0;
    assign m_eop    = m_valid && feop_q[rp_q];
    assign m_last   = m_valid && flast_q[rp_q];

endmodule

// File: tb/tb_img2col_reader.sv
// Randomized bench for img2col_reader: three parameterisations share a behavioural RAM and are
// checked against an img2col reference sequence built with plain nested loops.
module tb_img2col_reader;

    typedef struct packed {
        logic [15:0] data;
        logic        eop;
        logic        last;
    } elem_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start_v;
    logic [7:0]  base_addr;
    logic        m_ready;

    logic        busy_a [3];
    logic        done_a [3];
    logic        en_a   [3];
    logic        we_a   [3];
    logic        valid_a[3];
    logic        eop_a  [3];
    logic        last_a [3];
    logic [7:0]  addr_a [3];
    logic [15:0] dout_a [3];
    logic [15:0] data_a [3];

    int n_checks = 0;
    int n_errors = 0;

    elem_t exp_q[$];
    logic [15:0] obs_q[$];
    int got_n, done_n, en_cnt, first_addr, bad_addr, we_bad;

    always #5 clk = ~clk;

    img2col_reader #(.DATA_WIDTH(16), .ADDR_SIZE(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .base_addr(base_addr),
        .busy(busy_a[0]), .done(done_a[0]), .ram_addr(addr_a[0]), .ram_en(en_a[0]),
        .ram_we(we_a[0]), .ram_dout(dout_a[0]), .m_data(data_a[0]), .m_valid(valid_a[0]),
        .m_ready(m_ready), .m_eop(eop_a[0]), .m_last(last_a[0]));

    img2col_reader #(.DATA_WIDTH(16), .ADDR_SIZE(8), .STRIDE(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .base_addr(base_addr),
        .busy(busy_a[1]), .done(done_a[1]), .ram_addr(addr_a[1]), .ram_en(en_a[1]),
        .ram_we(we_a[1]), .ram_dout(dout_a[1]), .m_data(data_a[1]), .m_valid(valid_a[1]),
        .m_ready(m_ready), .m_eop(eop_a[1]), .m_last(last_a[1]));

    img2col_reader #(.DATA_WIDTH(16), .ADDR_SIZE(8), .PAD(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .base_addr(base_addr),
        .busy(busy_a[2]), .done(done_a[2]), .ram_addr(addr_a[2]), .ram_en(en_a[2]),
        .ram_we(we_a[2]), .ram_dout(dout_a[2]), .m_data(data_a[2]), .m_valid(valid_a[2]),
        .m_ready(m_ready), .m_eop(eop_a[2]), .m_last(last_a[2]));

    // RAM contents: mem[i] = i + 1, one-cycle read latency.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            if (en_a[k]) dout_a[k] <= 16'(addr_a[k]) + 16'd1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // 4x4 map, K=3; instance 1 uses stride 2, instance 2 has no padding.
    function automatic void build_exp(input int s, input int base);
        int pad, st, oh, ow, iy, ix;
        elem_t e;
        pad = (s == 2) ? 0 : 1;
        st  = (s == 1) ? 2 : 1;
        oh  = (4 + 2*pad - 3)/st + 1;
        ow  = oh;
        exp_q.delete();
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++) begin
                        iy = oy*st + ky - pad;
                        ix = ox*st + kx - pad;
                        if (iy >= 0 && iy < 4 && ix >= 0 && ix < 4)
                            e.data = 16'(((base + iy*4 + ix) % 256) + 1);
                        else
                            e.data = 16'd0;
                        e.eop  = (ky == 2) && (kx == 2);
                        e.last = (oy == oh-1) && (ox == ow-1) && e.eop;
                        exp_q.push_back(e);
                    end
    endfunction

    task automatic run_pass(input int s, input int base, input int rdy_pct,
                            input int stop_at, input bit pokes, input string name);
        bit prev_stall;
        logic [15:0] prev_data;
        logic prev_eop, prev_last;
        int tail;
        build_exp(s, base);
        obs_q.delete();
        got_n = 0; done_n = 0; en_cnt = 0; first_addr = -1; bad_addr = 0; we_bad = 0;
        prev_stall = 1'b0; prev_data = '0; prev_eop = 1'b0; prev_last = 1'b0; tail = 0;
        @(negedge clk);
        base_addr  = 8'(base);
        start_v[s] = 1'b1;
        m_ready    = 1'b0;
        @(negedge clk);
        start_v = '0;
        check({name, "_busy_after_start"}, busy_a[s], 1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            m_ready    = ($urandom_range(0, 99) < rdy_pct);
            start_v[s] = pokes && busy_a[s] && (cyc % 23 == 3);
            #1;
            if (we_a[s]) we_bad++;
            if (en_a[s]) begin
                if (en_cnt == 0) first_addr = int'(addr_a[s]);
                if (int'(addr_a[s]) < base || int'(addr_a[s]) > base + 15) bad_addr++;
                en_cnt++;
            end
            if (prev_stall) begin
                check({name, "_stall_valid"}, valid_a[s], 1);
                check({name, "_stall_data"}, data_a[s], prev_data);
                check({name, "_stall_eop"}, eop_a[s], prev_eop);
                check({name, "_stall_last"}, last_a[s], prev_last);
            end
            if (valid_a[s] && m_ready) begin
                if (got_n < exp_q.size()) begin
                    check($sformatf("%s_data%0d", name, got_n), data_a[s], exp_q[got_n].data);
                    check($sformatf("%s_eop%0d", name, got_n), eop_a[s], exp_q[got_n].eop);
                    check($sformatf("%s_last%0d", name, got_n), last_a[s], exp_q[got_n].last);
                end else begin
                    check({name, "_extra_element"}, got_n, exp_q.size());
                end
                obs_q.push_back(data_a[s]);
                got_n++;
            end
            prev_stall = valid_a[s] && !m_ready;
            prev_data  = data_a[s];
            prev_eop   = eop_a[s];
            prev_last  = last_a[s];
            if (done_a[s]) begin
                done_n++;
                check({name, "_done_after_last"}, got_n, exp_q.size());
            end
            if (stop_at > 0 && got_n == stop_at) break;
            if (done_n > 0) tail++;
            if (tail > 5) break;
            @(negedge clk);
        end
        start_v = '0;
        if (stop_at == 0) begin
            check({name, "_count"}, got_n, exp_q.size());
            check({name, "_done_once"}, done_n, 1);
            check({name, "_we_zero"}, we_bad, 0);
        end
    endtask

    task automatic check_first_patch(input string name);
        int fp[9] = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
        for (int i = 0; i < 9; i++)
            if (i < obs_q.size()) check($sformatf("%s_patch0_%0d", name, i), obs_q[i], fp[i]);
            else check($sformatf("%s_patch0_missing%0d", name, i), obs_q.size(), 9);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, busy_a[0], 0);
        check({name, "_done"}, done_a[0], 0);
        check({name, "_ram_en"}, en_a[0], 0);
        check({name, "_ram_addr"}, addr_a[0], 0);
        check({name, "_m_valid"}, valid_a[0], 0);
        check({name, "_m_eop"}, eop_a[0], 0);
        check({name, "_m_last"}, last_a[0], 0);
        check({name, "_m_data"}, data_a[0], 0);
    endtask

    initial begin
        int p11[9] = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
        rst_n = 1'b0; start_v = '0; base_addr = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        run_pass(0, 0, 100, 0, 1'b0, "t1");
        check_first_patch("t1");

        run_pass(0, 0, 50, 0, 1'b0, "t2");

        run_pass(1, 0, 60, 0, 1'b0, "t3");
        check("t3_addr_range", bad_addr, 0);
        for (int i = 0; i < 9; i++)
            if (27 + i < obs_q.size()) check($sformatf("t3_patch11_%0d", i), obs_q[27+i], p11[i]);

        run_pass(2, 100, 100, 0, 1'b0, "t4");
        check("t4_en_count", en_cnt, 36);
        check("t4_first_addr", first_addr, 100);
        check("t4_addr_range", bad_addr, 0);

        run_pass(0, 0, 70, 50, 1'b0, "t5a");
        check("t5a_reached_50", got_n, 50);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_rst_now");
        repeat (3) @(negedge clk);
        check_reset_outputs("t5_rst_held");
        rst_n = 1'b1;
        run_pass(0, 0, 100, 0, 1'b0, "t5b");
        check_first_patch("t5b");

        run_pass(0, 0, 80, 0, 1'b1, "t6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
